// File: rtl/can_bit_stuffer_stream.sv
// Streaming CAN bit stuffer: inserts a complement bit after STUFF_LEN identical stuffed-field bits.
// Optional stuff statistics (stuff_cnt, frame_done) are enabled by defining CAN_STUFF_STATS_EN.
module can_bit_stuffer_stream #(
    parameter int unsigned STUFF_LEN = 5,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_sof,
    input  logic             in_last,
    input  logic             in_stuff_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_is_stuff,
`ifdef CAN_STUFF_STATS_EN
    output logic [CNT_W-1:0] stuff_cnt,
    output logic             frame_done,
`endif
    output logic             out_last
);

    localparam int unsigned RW = $clog2(STUFF_LEN + 1);

    logic          out_valid_q, out_valid_d;
    logic          out_bit_q, out_bit_d;
    logic          out_is_stuff_q, out_is_stuff_d;
    logic          out_last_q, out_last_d;
    logic          run_bit_q, run_bit_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic          pend_stuff_q, pend_stuff_d;
    logic          pend_last_q, pend_last_d;
    logic [RW-1:0] cnt_next;
    logic          load;
    logic          in_xfer;

    always_comb begin
        load           = ~out_valid_q | out_ready;
        in_ready       = load & ~pend_stuff_q;
        in_xfer        = in_valid & in_ready;
        out_valid_d    = out_valid_q;
        out_bit_d      = out_bit_q;
        out_is_stuff_d = out_is_stuff_q;
        out_last_d     = out_last_q;
        run_bit_d      = run_bit_q;
        run_cnt_d      = run_cnt_q;
        pend_stuff_d   = pend_stuff_q;
        pend_last_d    = pend_last_q;
        cnt_next       = (in_sof || (in_bit != run_bit_q)) ? RW'(1) : run_cnt_q + RW'(1);
        if (load) begin
            if (pend_stuff_q) begin
                // The stuff bit opens a new run of its own polarity.
                out_valid_d    = 1'b1;
                out_bit_d      = ~run_bit_q;
                out_is_stuff_d = 1'b1;
                out_last_d     = pend_last_q;
                run_bit_d      = ~run_bit_q;
                run_cnt_d      = RW'(1);
                pend_stuff_d   = 1'b0;
                pend_last_d    = 1'b0;
            end else if (in_xfer) begin
                out_valid_d    = 1'b1;
                out_bit_d      = in_bit;
                out_is_stuff_d = 1'b0;
                out_last_d     = in_last;
                run_bit_d      = in_bit;
                if (in_stuff_en) begin
                    run_cnt_d = cnt_next;
                    if (cnt_next == RW'(STUFF_LEN)) begin
                        pend_stuff_d = 1'b1;
                        pend_last_d  = in_last;
                        out_last_d   = 1'b0;
                    end
                end else begin
                    run_cnt_d = '0;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_bit_q      <= 1'b1;
            out_is_stuff_q <= 1'b0;
            out_last_q     <= 1'b0;
            run_bit_q      <= 1'b1;
            run_cnt_q      <= '0;
            pend_stuff_q   <= 1'b0;
            pend_last_q    <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_bit_q      <= out_bit_d;
            out_is_stuff_q <= out_is_stuff_d;
            out_last_q     <= out_last_d;
            run_bit_q      <= run_bit_d;
            run_cnt_q      <= run_cnt_d;
            pend_stuff_q   <= pend_stuff_d;
            pend_last_q    <= pend_last_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_bit      = out_bit_q;
    assign out_is_stuff = out_is_stuff_q;
    assign out_last     = out_last_q;

`ifdef CAN_STUFF_STATS_EN
    logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;

    always_comb begin
        stuff_cnt_d = stuff_cnt_q;
        if (in_xfer && in_sof) begin
            stuff_cnt_d = '0;
        end else if (load && pend_stuff_q && (stuff_cnt_q != '1)) begin
            stuff_cnt_d = stuff_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuff_cnt_q <= '0;
        end else begin
            stuff_cnt_q <= stuff_cnt_d;
        end
    end

    assign stuff_cnt  = stuff_cnt_q;
    assign frame_done = out_valid_q & out_ready & out_last_q;
`endif

endmodule

// File: tb/tb_can_bit_stuffer_stream.sv
// Bench for can_bit_stuffer_stream: directed CAN stuffing cases plus random backpressured frames,
// checked against a frame-level queue model of the stuffing rule.
module tb_can_bit_stuffer_stream;

    localparam int unsigned SL = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_bit = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_last = 1'b0;
    logic       in_stuff_en = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_bit;
    logic       out_is_stuff;
    logic       out_last;
`ifdef CAN_STUFF_STATS_EN
    logic [7:0] stuff_cnt;
    logic       frame_done;
    int         fd_cnt = 0;
`endif

    can_bit_stuffer_stream #(.STUFF_LEN(SL), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .in_sof(in_sof), .in_last(in_last), .in_stuff_en(in_stuff_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .out_is_stuff(out_is_stuff),
`ifdef CAN_STUFF_STATS_EN
        .stuff_cnt(stuff_cnt), .frame_done(frame_done),
`endif
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct { logic b; logic sof; logic last; logic en; } in_t;
    typedef struct { logic b; logic stuff; logic last; } out_t;

    in_t  in_q[$];
    out_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   rdy_pct = 100;
    int   vld_pct = 100;
    int   stall_cnt = 0;
    int   frames_done_exp = 0;
    int   last_frame_stuffs = 0;
    logic stalled = 1'b0;
    logic [3:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected stuffed stream: after STUFF_LEN equal enabled bits, append the complement,
    // which then counts as the first bit of the next run.
    task automatic add_frame(input int n, input logic [63:0] bits, input logic [63:0] en,
                             input bit has_last);
        int   run = 0;
        logic prev = 1'b1;
        int   nst = 0;
        for (int i = 0; i < n; i++) begin
            in_t  x;
            out_t o;
            x.b = bits[i]; x.en = en[i]; x.sof = (i == 0); x.last = has_last && (i == n - 1);
            in_q.push_back(x);
            o.b = x.b; o.stuff = 1'b0; o.last = 1'b0;
            exp_q.push_back(o);
            if (x.en) begin
                run = (x.sof || x.b != prev) ? 1 : run + 1;
                prev = x.b;
                if (run == SL) begin
                    o.b = ~x.b; o.stuff = 1'b1;
                    exp_q.push_back(o);
                    prev = ~x.b;
                    run = 1;
                    nst++;
                end
            end else begin
                run = 0;
                prev = x.b;
            end
        end
        if (has_last) begin
            exp_q[exp_q.size() - 1].last = 1'b1;
            frames_done_exp++;
        end
        last_frame_stuffs = nst;
    endtask

    task automatic step();
        out_t e;
        @(negedge clk);
        if (stalled)
            chk("hold_out", {out_valid, out_bit, out_is_stuff, out_last}, held);
        out_ready = ($urandom_range(99) < rdy_pct);
        if (in_q.size() > 0 && $urandom_range(99) < vld_pct) begin
            in_valid = 1'b1;
            in_bit = in_q[0].b; in_sof = in_q[0].sof;
            in_last = in_q[0].last; in_stuff_en = in_q[0].en;
        end else begin
            in_valid = 1'b0;
        end
        #1;
        if (in_valid && !in_ready) stall_cnt++;
        if (in_valid && in_ready) void'(in_q.pop_front());
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_bit", 32'(out_bit), 32'(e.b));
                chk("out_is_stuff", 32'(out_is_stuff), 32'(e.stuff));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
        end
`ifdef CAN_STUFF_STATS_EN
        if (frame_done) fd_cnt++;
`endif
        stalled = out_valid && !out_ready;
        held = {out_valid, out_bit, out_is_stuff, out_last};
    endtask

    task automatic drain();
        int budget = 4000;
        while ((in_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
            step();
            budget--;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_valid", 32'(out_valid), 32'd0);
`ifdef CAN_STUFF_STATS_EN
        chk("frame_done_cnt", 32'(fd_cnt), 32'(frames_done_exp));
`endif
    endtask

    initial begin
        int   n;
        logic [63:0] bits, en;
        logic prev, enm;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bit", 32'(out_bit), 32'd1);
        chk("rst_out_is_stuff", 32'(out_is_stuff), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        stall_cnt = 0;
        add_frame(7, 64'h60, '1, 1);
        drain();
        chk("t1_in_ready_low_cycles", 32'(stall_cnt), 32'd1);

        stall_cnt = 0;
        add_frame(10, 64'h0, '1, 1);
        drain();
        chk("t2_in_ready_low_cycles", 32'(stall_cnt), 32'd1);
`ifdef CAN_STUFF_STATS_EN
        chk("t2_stuff_cnt", 32'(stuff_cnt), 32'(last_frame_stuffs));
`endif

        add_frame(9, 64'h1E0, '1, 1);
        drain();
        add_frame(6, 64'h1, '1, 1);
        drain();

        stall_cnt = 0;
        add_frame(8, 64'hFF, 64'h0, 1);
        drain();
        chk("t5_in_ready_low_cycles", 32'(stall_cnt), 32'd0);
        add_frame(14, 64'h3FFF, 64'h3F00, 1);
        drain();

        add_frame(3, 64'h0, '1, 0);
        add_frame(7, 64'h0, '1, 1);
        drain();
`ifdef CAN_STUFF_STATS_EN
        chk("sof_restart_stuff_cnt", 32'(stuff_cnt), 32'(last_frame_stuffs));
`endif

        rdy_pct = 50;
        vld_pct = 80;
        for (int f = 0; f < 1000; f++) begin
            n = $urandom_range(30, 1);
            prev = 1'($urandom_range(1));
            enm = 1'b1;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(3) == 0) prev = ~prev;
                if ($urandom_range(9) == 0) enm = ~enm;
                bits[i] = prev;
                en[i] = enm;
            end
            add_frame(n, bits, en, 1);
            if (f % 50 == 49) drain();
        end
        drain();

        add_frame(20, 64'h0, '1, 1);
        for (int i = 0; i < 9; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_bit", 32'(out_bit), 32'd1);
        chk("midrst_out_is_stuff", 32'(out_is_stuff), 32'd0);
        in_valid = 1'b0;
        in_q.delete();
        exp_q.delete();
        stalled = 1'b0;
        frames_done_exp = 0;
`ifdef CAN_STUFF_STATS_EN
        fd_cnt = 0;
        chk("midrst_stuff_cnt", 32'(stuff_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        add_frame(12, 64'h0, '1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
